mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/data SRAM between three requesters: BootLoader (port 0),
//  core data bus (port 1), core instruction fetch (port 2). Sits between the requester buses
//  and the SRAM macro. Uses an Ibex-style req/gnt/rvalid handshake on every requester port.
//  Pipelined: one grant per cycle, SRAM read latency 1, responses routed back by owner tag.
// PARAMETERS
//  NREQ     3        number of requester ports (fixed order: boot, data, instr)
//  DEPTH    1024     SRAM depth in 32-bit words (MEM_SIZE/4)
//  BASE     32'h0    byte base address of the SRAM window
//  AW       10       word-address width, $clog2(DEPTH)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         asynchronous active-low reset
//  lock_i     in   1         boot in progress (RstBoot); blocks ports 1,2
//  req_i      in   NREQ      per-port request, held until gnt
//  we_i       in   NREQ      per-port write enable
//  be_i       in   NREQx4    per-port byte enables
//  addr_i     in   NREQx32   per-port byte address
//  wdata_i    in   NREQx32   per-port write data
//  gnt_o      out  NREQ      per-port grant (combinational, one-hot or zero)
//  rvalid_o   out  NREQ      per-port response valid (one-hot or zero)
//  err_o      out  NREQ      per-port error, valid with rvalid
//  rdata_o    out  32        response data, shared; qualified by rvalid_o
//  mem_req_o  out  1         SRAM access strobe
//  mem_we_o   out  1         SRAM write enable
//  mem_be_o   out  4         SRAM byte enables
//  mem_addr_o out  AW        SRAM word address ((addr-BASE)>>2)
//  mem_wdata_o out 32        SRAM write data
//  mem_rdata_i in  32        SRAM read data, valid 1 cycle after mem_req_o
// BEHAVIOUR
//  - Reset: rvalid_o=0, err_o=0, rdata_o=0, mem_req_o=0, owner_q=0, rr_q=port1 preferred.
//  - Grant: port 0 has absolute priority. Ports 1/2 round-robin: last granted of the two
//    gets lowest priority next time; rr_q updates only on a grant to port 1 or 2.
//  - lock_i=1: gnt_o[1]=gnt_o[2]=0 regardless of req; port 0 unaffected; rr_q frozen.
//  - gnt_o[k] asserted same cycle as req_i[k] when k wins; at most one gnt per cycle.
//  - In-range grant (BASE <= addr < BASE+4*DEPTH): mem_req_o=1 with winner's we/be/addr/wdata
//    that cycle. Out-of-range grant: mem_req_o=0, err response scheduled.
//  - Response: exactly one rvalid per grant, exactly 1 cycle after gnt, on the granted port;
//    writes also return rvalid. rdata_o=mem_rdata_i for reads, 0 for writes and errors.
//    err_o=1 only for out-of-range. Back-to-back grants give back-to-back rvalids.
//  - State: owner_q (2b), vld_q, err_q, we_q registered on each grant; rr_q 1b.
//  - No req: gnt_o=0, mem_req_o=0, next cycle rvalid_o=0.
//  - Misaligned addr bits [1:0] ignored (word access, be selects bytes).
//  - Async reset mid-transaction: pending response is dropped, no rvalid after reset release.
//  - lock_i rising while a CPU response is pending: that response still delivered next cycle.
// STRUCTURE
//  - Package mem_arb_pkg: NREQ, enum req_idx_e {REQ_BOOT=0, REQ_DATA=1, REQ_INSTR=2},
//    resp_tag_t struct {owner, vld, err, we}.
//  - Sub-module mem_arb_pick: combinational winner select (req, lock, rr_q -> one-hot gnt,
//    next rr). Top holds address decode, request mux, response registers, rdata routing.
// TESTING
//  - Single read port 2 addr 0x10, SRAM word4=0xDEADBEEF -> gnt_o=3'b100 cyc0, mem_addr=4,
//    rvalid_o=3'b100 cyc1, rdata_o=0xDEADBEEF, err_o=0.
//  - Ports 1,2 req every cycle for 6 cycles, lock=0 -> grants alternate 1,2,1,2,1,2;
//    rvalids follow one cycle later in same order.
//  - All three req, lock=0 -> port 0 granted every cycle while held; 1/2 gnt=0.
//  - lock_i=1, ports 1,2 req -> no grant, mem_req_o=0; drop lock -> port 1 granted first.
//  - Port 1 write addr BASE+4*DEPTH -> gnt cyc0, mem_req_o=0, cyc1 rvalid_o[1]=1, err_o[1]=1,
//    SRAM contents unchanged.
//  - Grant port 2 then assert rst_n=0 before next edge -> rvalid_o stays 0 after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the boot/data/instr SRAM port arbiter.
// Port indices, response tag and one-hot helper.
package mem_arb_pkg;

  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    REQ_BOOT  = 2'd0,
    REQ_DATA  = 2'd1,
    REQ_INSTR = 2'd2
  } req_idx_e;

  typedef struct packed {
    logic [1:0] owner;
    logic       vld;
    logic       err;
    logic       we;
  } resp_tag_t;

  function automatic logic [NREQ-1:0] idx2oh(
    input logic [1:0] idx
  );
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (idx == 2'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select: boot port absolute, data/instr round-robin.
// rr_i=0 prefers data, rr_i=1 prefers instr.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic            lock_i,
  input  logic            rr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            rr_o
);

  logic boot;
  logic cpu_ok;
  logic p_data;
  logic p_instr;

  assign boot    = req_i[REQ_BOOT];
  assign cpu_ok  = ~boot & ~lock_i;
  assign p_data  = cpu_ok & req_i[REQ_DATA]
                 & (~req_i[REQ_INSTR] | ~rr_i);
  assign p_instr = cpu_ok & req_i[REQ_INSTR]
                 & (~req_i[REQ_DATA] | rr_i);

  // Terms are mutually exclusive by construction.
  always_comb begin
    gnt_o = '0;
    rr_o  = rr_i;
    unique case (1'b1)
      boot: begin
        gnt_o[REQ_BOOT] = 1'b1;
      end
      p_data: begin
        gnt_o[REQ_DATA] = 1'b1;
        rr_o            = 1'b1;
      end
      p_instr: begin
        gnt_o[REQ_INSTR] = 1'b1;
        rr_o             = 1'b0;
      end
      default: begin
        gnt_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port req/gnt/rvalid front end for a single-port SRAM.
// One grant per cycle, responses one cycle later by owner tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lock_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      we_i,
  input  logic [NREQ-1:0][3:0] be_i,
  input  logic [NREQ-1:0][31:0] addr_i,
  input  logic [NREQ-1:0][31:0] wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      rvalid_o,
  output logic [NREQ-1:0]      err_o,
  output logic [31:0]          rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic            rr_q;
  logic            rr_d;
  resp_tag_t       tag_q;
  resp_tag_t       tag_d;
  logic            granted;
  logic            in_rng;
  logic [31:0]     off;
  logic            sel_we;
  logic [3:0]      sel_be;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [1:0]      sel_idx;

  mem_arb_pick u_pick (
    .req_i  (req_i),
    .lock_i (lock_i),
    .rr_i   (rr_q),
    .gnt_o  (gnt_o),
    .rr_o   (rr_d)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_o[k]) begin
        sel_we    = we_i[k];
        sel_be    = be_i[k];
        sel_addr  = addr_i[k];
        sel_wdata = wdata_i[k];
        sel_idx   = 2'(k);
      end
    end
  end

  // Addresses below BASE wrap to large offsets and fall out of range.
  assign granted = |gnt_o;
  assign off     = sel_addr - BASE;
  assign in_rng  = off < LIMIT;

  assign mem_req_o   = granted & in_rng;
  assign mem_we_o    = mem_req_o & sel_we;
  assign mem_be_o    = sel_be;
  assign mem_addr_o  = off[AW+1:2];
  assign mem_wdata_o = sel_wdata;

  always_comb begin
    tag_d       = '0;
    tag_d.owner = sel_idx;
    tag_d.vld   = granted;
    tag_d.err   = granted & ~in_rng;
    tag_d.we    = sel_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      rr_q  <= 1'b0;
    end else begin
      tag_q <= tag_d;
      rr_q  <= rr_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (tag_q.vld) begin
      rvalid_o = idx2oh(tag_q.owner);
      if (tag_q.err) begin
        err_o = idx2oh(tag_q.owner);
      end else if (!tag_q.we) begin
        rdata_o = mem_rdata_i;
      end
    end
  end

endmodule
